// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: round-robin scheduler for the register file write port, with a register clear sequence
module regfile_wr_sched #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data1,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ldreg,
    output logic [ADDR_W-1:0] drmux,
    output logic [DATA_W-1:0] wr_bus,
    output logic              last_gnt
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    state_t state, state_nx;
    logic rr, rr_nx, accept, start, clr_more, clr_last;
    logic ldreg_nx, clr_busy_nx, clr_done_nx, last_gnt_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, drmux_nx;
    logic [DATA_W-1:0] wr_bus_nx;

    // A pending clr_start blocks arbitration so clear always wins the collision
    assign req_ready[0] = state == IDLE && !clr_start && req_valid[0] && (!req_valid[1] || !rr);
    assign req_ready[1] = state == IDLE && !clr_start && req_valid[1] && (!req_valid[0] || rr);
    assign accept   = |req_ready;
    assign start    = state == IDLE && clr_start;
    assign clr_last = state == CLEAR && &cnt;
    assign clr_more = state == CLEAR && !(&cnt);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            rr       <= 1'b0;
            cnt      <= '0;
            ldreg    <= 1'b0;
            drmux    <= '0;
            wr_bus   <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            last_gnt <= 1'b0;
        end else begin
            state    <= state_nx;
            rr       <= rr_nx;
            cnt      <= cnt_nx;
            ldreg    <= ldreg_nx;
            drmux    <= drmux_nx;
            wr_bus   <= wr_bus_nx;
            clr_busy <= clr_busy_nx;
            clr_done <= clr_done_nx;
            last_gnt <= last_gnt_nx;
        end
    end

    always_comb begin
        state_nx = state == IDLE ? (clr_start ? CLEAR : IDLE) :
                   state == CLEAR ? (&cnt ? DONE : CLEAR) : IDLE;
    end

    // cnt holds the index currently on drmux while clearing
    always_comb begin
        cnt_nx      = state == CLEAR ? cnt + 1'b1 : '0;
        ldreg_nx    = start || accept || clr_more;
        clr_busy_nx = start || clr_more;
        clr_done_nx = clr_last;
        drmux_nx    = start ? '0 : clr_more ? cnt + 1'b1 :
                      accept ? (req_ready[1] ? req_addr1 : req_addr0) : drmux;
        wr_bus_nx   = start ? '0 : accept ? (req_ready[1] ? req_data1 : req_data0) : wr_bus;
        rr_nx       = accept ? req_ready[0] : rr;
        last_gnt_nx = accept ? req_ready[1] : last_gnt;
    end
endmodule
